// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard and pipeline stall/flush controller (clk CLK, reset RST; outputs pc_en, pipe_en, flush, stall_cnt, state)
module hazard_scoreboard #(
  parameter int NPIPE = 4,
  parameter int REGW  = 5,
  parameter int LATW  = 3,
  parameter int PCW   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic [REGW-1:0]  rsel1,
  input  logic [REGW-1:0]  rsel2,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [REGW-1:0]  wsel_id,
  input  logic             wen_id,
  input  logic [LATW-1:0]  lat_id,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic [NPIPE-1:0] pipe_en,
  output logic [NPIPE-1:0] flush,
  output logic [PCW-1:0]   stall_cnt,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, REDIR = 2'd2} state_t;
  state_t st, st_n;
  logic [LATW-1:0] cnt [2**REGW];
  logic mem_wait, hazard, issue;
  assign state    = st;
  assign mem_wait = (dmem_req && !dhit) || (st == DWAIT && !dhit);
  assign hazard   = (use_rs && rsel1 != '0 && cnt[rsel1] != '0) ||
                    (use_rt && rsel2 != '0 && cnt[rsel2] != '0);
  assign issue    = pipe_en[1] && !flush[1] && wen_id && wsel_id != '0;
  always_comb begin
    pc_en   = 1'b1;
    pipe_en = '1;
    flush   = '0;
    if (RST) begin
      pc_en   = 1'b0;
      pipe_en = '0;
      flush   = '1;
    end else if (mem_wait) begin
      pc_en   = 1'b0;
      pipe_en = '0;
    end else if (branch_taken) begin
      flush[1:0] = 2'b11;
    end else if (hazard) begin
      pc_en      = 1'b0;
      pipe_en[0] = 1'b0;
      flush[1]   = 1'b1;
    end else if (!ihit) begin
      pc_en    = 1'b0;
      flush[0] = 1'b1;
    end
  end
  always_comb begin
    st_n = (st == RUN)   ? (mem_wait ? DWAIT : (branch_taken && !ihit) ? REDIR : RUN) :
           (st == DWAIT) ? (dhit ? RUN : DWAIT) :
           (st == REDIR) ? (ihit ? RUN : REDIR) : RUN;
  end
  always_ff @(posedge CLK) begin
    st <= RST ? RUN : st_n;
  end
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2**REGW; i++)
      if (RST)
        cnt[i] <= '0;
      else if (pipe_en[1])
        cnt[i] <= (issue && wsel_id == REGW'(i)) ? lat_id : (cnt[i] != '0 ? cnt[i] - 1'b1 : '0);
  end
  always_ff @(posedge CLK) begin
    if (RST)
      stall_cnt <= '0;
    else if (!pc_en && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
